// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: frame geometry, opcodes and FSM states
// shared by the SPI-RAM master and slave.
package spi_ram_pkg;

  localparam int FRAME_W = 10;
  localparam int DATA_W  = 8;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SHIFT,
    S_WAIT,
    S_RECV,
    S_GAP
  } state_t;

endpackage

// File: rtl/spi_shift_reg.sv
// spi_shift_reg: parallel-load MSB-first shift register;
// q[W-1] is the serial output, sin the serial capture.
module spi_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         shift,
  input  logic         sin,
  output logic [W-1:0] q
);

  // load wins over shift; shift moves towards the MSB
  always_ff @(posedge clk) begin
    if (rst)
      q <= '0;
    else if (load)
      q <= din;
    else if (shift)
      q <= {q[W-2:0], sin};
  end

endmodule

// File: rtl/spi_ram_master.sv
// spi_ram_master: turns host commands into 10-bit SPI
// frames and captures the 8-bit read-back from MISO.
module spi_ram_master #(
  parameter int FRAME_W    = spi_ram_pkg::FRAME_W,
  parameter int DATA_W     = spi_ram_pkg::DATA_W,
  parameter int TURNAROUND = 2,
  parameter int GAP        = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              SS_n,
  output logic              MOSI,
  input  logic              MISO
);

  import spi_ram_pkg::*;

  localparam logic [3:0] BIT_LAST  = 4'(FRAME_W - 1);
  localparam logic [3:0] RX_LAST   = 4'(DATA_W - 1);
  localparam logic [3:0] WAIT_LAST = 4'(TURNAROUND - 1);
  localparam logic [3:0] GAP_LAST  = 4'(GAP - 1);

  state_t              state;
  logic [3:0]          bit_cnt;
  logic [3:0]          wait_cnt;
  logic [3:0]          gap_cnt;
  logic                rd_q;
  logic [FRAME_W-1:0]  tx_q;
  logic [DATA_W-1:0]   rx_q;
  logic                accept;
  logic                tx_shift;
  logic                rx_shift;

  assign cmd_ready = (state == S_IDLE) && !rst;
  assign busy      = !cmd_ready;
  assign accept    = cmd_valid && cmd_ready;

  assign tx_shift = (state == S_START) ||
                    (state == S_SHIFT);

  // first sample lands on the last WAIT edge, so the
  // final RECV edge carries no shift
  assign rx_shift =
    ((state == S_WAIT) && (wait_cnt == WAIT_LAST)) ||
    ((state == S_RECV) && (bit_cnt != RX_LAST));

  spi_shift_reg #(.W(FRAME_W)) u_tx (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .din   ({cmd_op, cmd_data}),
    .shift (tx_shift),
    .sin   (1'b0),
    .q     (tx_q)
  );

  spi_shift_reg #(.W(DATA_W)) u_rx (
    .clk   (clk),
    .rst   (rst),
    .load  (1'b0),
    .din   ('0),
    .shift (rx_shift),
    .sin   (MISO),
    .q     (rx_q)
  );

  // transaction sequencer with registered pin outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      SS_n      <= 1'b1;
      MOSI      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      bit_cnt   <= '0;
      wait_cnt  <= '0;
      gap_cnt   <= '0;
      rd_q      <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            state <= S_START;
            SS_n  <= 1'b0;
            MOSI  <= 1'b0;
            rd_q  <= (cmd_op == OP_RD_DATA);
          end
        end
        S_START: begin
          state   <= S_SHIFT;
          MOSI    <= tx_q[FRAME_W-1];
          bit_cnt <= '0;
        end
        S_SHIFT: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            MOSI    <= 1'b0;
            if (rd_q) begin
              state    <= S_WAIT;
              wait_cnt <= '0;
            end else begin
              state   <= S_GAP;
              SS_n    <= 1'b1;
              gap_cnt <= '0;
            end
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
            MOSI    <= tx_q[FRAME_W-1];
          end
        end
        S_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            state    <= S_RECV;
            wait_cnt <= '0;
            bit_cnt  <= '0;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        S_RECV: begin
          if (bit_cnt == RX_LAST) begin
            state     <= S_GAP;
            SS_n      <= 1'b1;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            rsp_valid <= 1'b1;
            rsp_data  <= rx_q;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state   <= S_IDLE;
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
